// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment display controller.
// Selects one of NCH hex channels, snapshots it once per scan frame so the
// displayed value never tears, then scans DIGITS anodes with a programmable
// prescaler. Adds per-digit decimal point, leading-zero blanking and blink.
// Channel 0 is a CPU-loaded register; channels 1..NCH-1 come from test_data.
module seven_seg_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int NCH        = 8,
    parameter int SCAN_DIV   = 18,
    parameter int BLINK_DIV  = 25,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_we,
    input  logic [4*DIGITS-1:0]     cpu_data,
    input  logic [NCH*4*DIGITS-1:0] test_data,
    input  logic [$clog2(NCH)-1:0]  sel,
    input  logic [DIGITS-1:0]       dp_in,
    input  logic                    lzb_en,
    input  logic                    blink_en,
    output logic                    frame_tick,
    output logic [DIGITS-1:0]       an,
    output logic [7:0]              segment
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = $clog2(DIGITS);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    // Polarity mask: XOR with this turns an active-high pattern into the pin level.
    localparam logic          POL        = (ACTIVE_LOW != 0);

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // State registers
    logic [W-1:0]         cpu_reg_q,    cpu_reg_d;
    logic [W-1:0]         shadow_q,     shadow_d;
    logic [SCAN_DIV-1:0]  scan_cnt_q,   scan_cnt_d;
    logic [BLINK_DIV-1:0] blink_cnt_q,  blink_cnt_d;
    logic [DW-1:0]        digit_idx_q,  digit_idx_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0]    an_q,         an_d;
    logic [7:0]           seg_q,        seg_d;

    // Combinational helpers
    logic                 tick;
    logic                 snap;
    logic [W-1:0]         chan [NCH];
    logic [W-1:0]         chan_sel;
    logic [3:0]           nib [DIGITS];
    logic [DIGITS-1:0]    nib_nz;
    logic [DW-1:0]        hi_nib;
    logic                 blank;
    logic [DIGITS-1:0]    an_act;
    logic [7:0]           seg_act;

    // The channel-0 slice of test_data is replaced by the CPU register.
    logic                 unused_ch0;
    assign unused_ch0 = ^test_data[W-1:0];

    // Channel 0 is the CPU register, the rest are taken straight from test_data.
    assign chan[0] = cpu_reg_q;
    generate
        for (genvar gi = 1; gi < NCH; gi++) begin : g_chan
            assign chan[gi] = test_data[gi*W +: W];
        end
    endgenerate

    // Split the frozen shadow value into digit nibbles (digit 0 = LS nibble).
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi]    = shadow_q[gi*4 +: 4];
            assign nib_nz[gi] = |nib[gi];
        end
    endgenerate

    // Channel mux; any select value without a matching channel falls back to channel 0.
    always_comb begin
        chan_sel = chan[0];
        for (int c = 1; c < NCH; c++) begin
            if (int'(sel) == c) begin
                chan_sel = chan[c];
            end
        end
    end

    // Position of the most significant non-zero nibble (0 when the value is zero,
    // which keeps digit 0 visible as a single "0").
    always_comb begin
        hi_nib = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (nib_nz[i]) begin
                hi_nib = DW'(i);
            end
        end
    end

    // Next-state logic: prescaler, digit stepping, frame snapshot, CPU load, output decode.
    always_comb begin
        tick         = &scan_cnt_q;
        snap         = tick && (digit_idx_q == LAST_DIGIT);

        scan_cnt_d   = scan_cnt_q + SCAN_DIV'(1);
        blink_cnt_d  = blink_cnt_q + BLINK_DIV'(1);

        digit_idx_d  = digit_idx_q;
        if (tick) begin
            digit_idx_d = (digit_idx_q == LAST_DIGIT) ? '0 : digit_idx_q + DW'(1);
        end

        // The snapshot reads the pre-edge CPU register, so a coincident write
        // only shows up on the following frame.
        shadow_d     = snap ? chan_sel : shadow_q;
        frame_tick_d = snap;
        cpu_reg_d    = cpu_we ? cpu_data : cpu_reg_q;

        an_act              = '0;
        an_act[digit_idx_q] = 1'b1;
        if (blink_en && blink_cnt_q[BLINK_DIV-1]) begin
            an_act = '0;
        end

        blank   = lzb_en && (digit_idx_q > hi_nib);
        seg_act = {dp_in[digit_idx_q], blank ? 7'h00 : hex7(nib[digit_idx_q])};

        an_d    = an_act ^ {DIGITS{POL}};
        seg_d   = seg_act ^ {8{POL}};
    end

    // Counters and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            digit_idx_q <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    // CPU register, frame shadow and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_reg_q    <= '0;
            shadow_q     <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cpu_reg_q    <= cpu_reg_d;
            shadow_q     <= shadow_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Registered pin drivers; reset leaves every anode and segment inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= {DIGITS{POL}};
            seg_q <= {8{POL}};
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign an         = an_q;
    assign segment    = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (DIGITS=4, NCH=4, SCAN_DIV=2, BLINK_DIV=6, active-low).
// A cycle-count model predicts an/segment/frame_tick every cycle; directed
// literal checks pin the model's interpretation at key points.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_data = '0;
    logic [63:0] test_data = '0;
    logic [1:0]  sel = '0;
    logic [3:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic        blink_en = 1'b0;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  segment;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    seven_seg_scan_ctrl #(
        .DIGITS    (4),
        .NCH       (4),
        .SCAN_DIV  (2),
        .BLINK_DIV (6),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_data  (cpu_data),
        .test_data (test_data),
        .sel       (sel),
        .dp_in     (dp_in),
        .lzb_en    (lzb_en),
        .blink_en  (blink_en),
        .frame_tick(frame_tick),
        .an        (an),
        .segment   (segment)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tab [16];
    int          n;          // clock edges since reset release
    logic [15:0] m_cpu;
    logic [15:0] m_shadow;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_ft;

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    function automatic logic [7:0] model_seg(input logic [15:0] val, input int d,
                                             input logic [3:0] dp, input logic lzb);
        logic [15:0] upper;
        logic [6:0]  s;
        upper = val >> (4 * d);
        s     = seg_tab[upper[3:0]];
        if (lzb && d > 0 && upper == 16'h0) s = 7'h00;
        return ~{dp[d], s};
    endfunction

    // Model: slot length 4 clocks, frame 16 clocks, blink phase 32 clocks.
    always @(posedge clk or posedge rst) begin
        int   d;
        logic blink;
        if (rst) begin
            n        <= 0;
            m_cpu    <= '0;
            m_shadow <= '0;
            exp_an   <= 4'hF;
            exp_seg  <= 8'hFF;
            exp_ft   <= 1'b0;
        end else begin
            d     = (n / 4) % 4;
            blink = blink_en && ((n % 64) >= 32);
            exp_an  <= blink ? 4'hF : ~(4'b0001 << d);
            exp_seg <= model_seg(m_shadow, d, dp_in, lzb_en);
            if (n % 16 == 15) begin
                exp_ft   <= 1'b1;
                m_shadow <= (sel == 2'd0) ? m_cpu : test_data[int'(sel)*16 +: 16];
            end else begin
                exp_ft <= 1'b0;
            end
            if (cpu_we) m_cpu <= cpu_data;
            n <= n + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (an !== exp_an || segment !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL model_cycle t=%0t: an=%b segment=%h frame_tick=%b, expected an=%b segment=%h frame_tick=%b",
                         $time, an, segment, frame_tick, exp_an, exp_seg, exp_ft);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string name, input logic [3:0] a_exp, input logic [7:0] s_exp);
        checks++;
        if (an !== a_exp || segment !== s_exp) begin
            failures++;
            $display("FAIL %s: an=%b segment=%h, expected an=%b segment=%h", name, an, segment, a_exp, s_exp);
        end else begin
            $display("check %s: an=%b segment=%h ok", name, an, segment);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end else begin
            $display("check %s: %b ok", name, act);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    // Returns at the negedge following the snapshot edge (frame_tick high).
    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: frame_tick not seen within 40 cycles, expected a pulse", name);
        end
    endtask

    task automatic cpu_write(input logic [15:0] v);
        cpu_we   = 1'b1;
        cpu_data = v;
        @(negedge clk);
        cpu_we   = 1'b0;
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int blanks = 0;
        int run    = 0;
        int maxrun = 0;

        test_data = {16'h0F00, 16'hABCD, 16'h5555, 16'hDEAD};

        // 1. reset state and first digit step
        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        @(negedge clk);
        check_lit("reset_outputs", 4'hF, 8'hFF);
        check_bit("reset_frame_tick", frame_tick, 1'b0);
        step(2);
        rst = 1'b0;
        step(4);
        check_lit("digit0_before_step", 4'b1110, 8'hC0);
        step(1);
        check_lit("digit1_after_4_clocks", 4'b1101, 8'hC0);

        // 2. CPU value 1234
        cpu_write(16'h1234);
        wait_frame("frame_1234");
        step(1);
        check_lit("1234_digit0", 4'b1110, 8'h99);
        step(12);
        check_lit("1234_digit3", 4'b0111, 8'hF9);

        // 3. leading-zero blanking on 0050, then decimal point on digit 2
        lzb_en = 1'b1;
        cpu_write(16'h0050);
        wait_frame("frame_0050");
        step(1);
        check_lit("lzb_digit0", 4'b1110, 8'hC0);
        step(4);
        check_lit("lzb_digit1", 4'b1101, 8'h92);
        step(4);
        check_lit("lzb_digit2", 4'b1011, 8'hFF);
        step(4);
        check_lit("lzb_digit3", 4'b0111, 8'hFF);
        dp_in = 4'b0100;
        wait_frame("frame_0050_dp");
        step(1);
        check_lit("lzb_dp_digit0", 4'b1110, 8'hC0);
        step(8);
        check_lit("lzb_dp_digit2", 4'b1011, 8'h7F);

        // 4. select change mid-frame is deferred to the next snapshot
        lzb_en = 1'b0;
        dp_in  = 4'b0000;
        cpu_write(16'h1234);
        wait_frame("frame_sel_pre");
        step(5);
        sel = 2'd2;
        step(4);
        check_lit("sel_change_old_digit2", 4'b1011, 8'hA4);
        step(4);
        check_lit("sel_change_old_digit3", 4'b0111, 8'hF9);
        wait_frame("frame_ch2");
        step(1);
        check_lit("ch2_digit0", 4'b1110, 8'hA1);

        // 5. CPU write on the exact snapshot edge
        sel = 2'd0;
        step(14);
        cpu_we   = 1'b1;
        cpu_data = 16'hFFFF;
        @(negedge clk);
        cpu_we = 1'b0;
        check_bit("snapshot_edge_tick", frame_tick, 1'b1);
        step(1);
        check_lit("coincident_write_old", 4'b1110, 8'h99);
        wait_frame("frame_ffff");
        step(1);
        check_lit("ffff_digit0", 4'b1110, 8'h8E);
        for (int k = 1; k < 4; k++) begin
            step(4);
            check_lit($sformatf("ffff_digit%0d", k), ~(4'b0001 << k), 8'h8E);
        end

        // 6. blink: 32 dark cycles out of every 64
        blink_en = 1'b1;
        repeat (128) begin
            @(negedge clk);
            if (an === 4'hF) begin
                blanks++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check_int("blink_dark_cycles", blanks, 64);
        check_int("blink_dark_window", maxrun, 32);
        blink_en = 1'b0;

        // asynchronous reset mid-frame
        step(7);
        #2 rst = 1'b1;
        #1;
        check_lit("async_reset_immediate", 4'hF, 8'hFF);
        check_bit("async_reset_frame_tick", frame_tick, 1'b0);
        step(2);
        rst = 1'b0;
        wait_frame("frame_after_reset");
        step(1);
        check_lit("cpu_reg_cleared", 4'b1110, 8'hC0);
        step(20);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
